// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_t;

    localparam logic [15:0] DEFAULT_TX_DATA_ADDR = 16'hF800;
    localparam logic [15:0] DEFAULT_TX_STAT_ADDR = 16'hF801;

    // Status word bit positions
    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_FULL    = 1;
    localparam int unsigned STAT_EMPTY   = 2;
    localparam int unsigned STAT_OVF     = 3;
    localparam int unsigned STAT_CNT_LSB = 4;

    // FIFO fill level clipped to the 4-bit status field
    function automatic logic [3:0] sat_count4(input int unsigned cnt);
        return (cnt > 15) ? 4'hF : cnt[3:0];
    endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// CPU data-bus slice seen by the UART: address/store data in, select/load data out.
interface uart_tx_mmio_if #(
    parameter int unsigned WORD_WIDTH = 16
);
    logic [WORD_WIDTH-1:0] data_addr;
    logic [WORD_WIDTH-1:0] data_out;
    logic                  mem_write_en;
    logic                  sel;
    logic [WORD_WIDTH-1:0] rd_data;

    modport master (
        output data_addr, data_out, mem_write_en,
        input  sel, rd_data
    );

    modport slave (
        input  data_addr, data_out, mem_write_en,
        output sel, rd_data
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read and occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    // A push into a full FIFO is legal when a pop frees a slot on the same edge
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Storage array; no reset needed since reads are gated by empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally; count tracks net push/pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus decode, overflow flag, serial FSM.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int unsigned           WORD_WIDTH   = 16,
    parameter int unsigned           FIFO_DEPTH   = 8,
    parameter int unsigned           CLKS_PER_BIT = 434,
    parameter logic [WORD_WIDTH-1:0] TX_DATA_ADDR = WORD_WIDTH'(DEFAULT_TX_DATA_ADDR),
    parameter logic [WORD_WIDTH-1:0] TX_STAT_ADDR = WORD_WIDTH'(DEFAULT_TX_STAT_ADDR)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_stb_800k,
    uart_tx_mmio_if.slave        bus,
    output logic                 tx
);
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    uart_state_t       state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_q;
    logic [7:0]        shift_q;
    logic              tx_q;
    logic              ovf_q;

    logic              hit_data, hit_stat, bus_wr, push_req, clr_req;
    logic              baud_last, fifo_pop, fifo_push, ovf_set;
    logic              fifo_full, fifo_empty;
    logic [7:0]        fifo_rdata;
    logic [CNT_W-1:0]  fifo_count;
    logic [WORD_WIDTH-1:0] rd_data_w;
    logic              unused_data_hi;

    assign hit_data  = (bus.data_addr == TX_DATA_ADDR);
    assign hit_stat  = (bus.data_addr == TX_STAT_ADDR);
    // The CPU holds mem_write_en for a whole step; the strobe makes it one write
    assign bus_wr    = clk_stb_800k && bus.mem_write_en;
    assign push_req  = bus_wr && hit_data;
    assign clr_req   = bus_wr && hit_stat;
    assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign fifo_pop  = !fifo_empty &&
                       ((state_q == StIdle) || ((state_q == StStop) && baud_last));
    assign fifo_push = push_req && (!fifo_full || fifo_pop);
    assign ovf_set   = push_req && fifo_full && !fifo_pop;

    assign unused_data_hi = ^bus.data_out[WORD_WIDTH-1:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (bus.data_out[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sticky overflow; a set on the same edge as a clear wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_q <= 1'b1;
        end else if (clr_req) begin
            ovf_q <= 1'b0;
        end
    end

    // Serial engine: start, 8 data bits LSB first, stop; tx is registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        state_q <= StStart;
                        shift_q <= fifo_rdata;
                        baud_q  <= '0;
                        tx_q    <= 1'b0;
                    end
                end
                StStart: begin
                    if (baud_last) begin
                        state_q <= StData;
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                StData: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= StStop;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                StStop: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        // Chain straight into the next start bit for gapless frames
                        if (!fifo_empty) begin
                            state_q <= StStart;
                            shift_q <= fifo_rdata;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Status word for loads; zero for any other address
    always_comb begin
        rd_data_w = '0;
        if (hit_stat) begin
            rd_data_w[STAT_BUSY]          = (state_q != StIdle);
            rd_data_w[STAT_FULL]          = fifo_full;
            rd_data_w[STAT_EMPTY]         = fifo_empty;
            rd_data_w[STAT_OVF]           = ovf_q;
            rd_data_w[STAT_CNT_LSB +: 4]  = sat_count4(32'(fifo_count));
        end
    end

    assign bus.sel     = hit_data || hit_stat;
    assign bus.rd_data = rd_data_w;
    assign tx          = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed self-checking bench for uart_tx_mmio (CLKS_PER_BIT=4, FIFO_DEPTH=4).
module tb_uart_tx_mmio;

    localparam int unsigned CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic stb = 1'b0;
    logic tx;

    int n_tests = 0;
    int n_fail  = 0;

    logic line_q [$];
    logic exp_q  [$];

    uart_tx_mmio_if #(.WORD_WIDTH(16)) bus_if ();

    uart_tx_mmio #(
        .WORD_WIDTH   (16),
        .FIFO_DEPTH   (4),
        .CLKS_PER_BIT (CPB),
        .TX_DATA_ADDR (16'hF800),
        .TX_STAT_ADDR (16'hF801)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_stb_800k (stb),
        .bus          (bus_if),
        .tx           (tx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Park the bus on the status address so rd_data always shows status
    task automatic bus_idle();
        bus_if.data_addr    = 16'hF801;
        bus_if.data_out     = 16'h0000;
        bus_if.mem_write_en = 1'b0;
        stb                 = 1'b0;
    endtask

    task automatic bus_drive(input logic [15:0] a, input logic [15:0] d);
        bus_if.data_addr    = a;
        bus_if.data_out     = d;
        bus_if.mem_write_en = 1'b1;
        stb                 = 1'b1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        bus_drive(a, d);
        step();
        bus_idle();
        #1;
    endtask

    // Expected line samples for one frame, one sample per clock
    task automatic add_frame(input logic [7:0] b);
        logic v;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      v = 1'b0;
            else if (k == 9) v = 1'b1;
            else             v = b[k-1];
            for (int c = 0; c < CPB; c++) exp_q.push_back(v);
        end
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
    endtask

    task automatic check_line(input string tag);
        logic o;
        chk({tag, "_len"}, line_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            o = (i < line_q.size()) ? line_q[i] : 1'bx;
            chk($sformatf("%s_s%0d", tag, i), {31'd0, o}, {31'd0, exp_q[i]});
        end
        line_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic saw_low;
        bus_idle();

        // Reset state
        rst = 1'b0;
        repeat (3) step();
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_stat", bus_if.rd_data, 32'h0004);
        chk("rst_sel_stat", {31'd0, bus_if.sel}, 32'd1);
        rst = 1'b1;
        step();
        bus_if.data_addr = 16'hF7FF;
        #1;
        chk("sel_f7ff", {31'd0, bus_if.sel}, 32'd0);
        bus_if.data_addr = 16'hF800;
        #1;
        chk("sel_f800", {31'd0, bus_if.sel}, 32'd1);
        chk("rd_f800", bus_if.rd_data, 32'h0000);
        bus_idle();
        #1;
        chk("idle_stat", bus_if.rd_data, 32'h0004);

        // Single byte 0x55
        bus_write(16'hF800, 16'h1255);
        chk("single_cnt1", bus_if.rd_data, 32'h0010);
        step();
        chk("single_busy", bus_if.rd_data, 32'h0005);
        for (int i = 0; i < 10 * CPB; i++) begin
            line_q.push_back(tx);
            step();
        end
        add_frame(8'h55);
        check_line("single");
        chk("single_done", bus_if.rd_data, 32'h0004);

        // Strobe gating: write enable held 20 clocks, one strobe
        for (int i = 0; i < 80; i++) begin
            if (i < 20) begin
                bus_if.data_addr    = 16'hF800;
                bus_if.data_out     = 16'h003C;
                bus_if.mem_write_en = 1'b1;
                stb                 = (i == 5);
            end else begin
                bus_idle();
            end
            step();
            line_q.push_back(tx);
        end
        add_idle(6);
        add_frame(8'h3C);
        add_idle(34);
        check_line("gate");
        #1;
        chk("gate_done", bus_if.rd_data, 32'h0004);

        // Overflow: six strobed writes back to back
        for (int i = 0; i < 208; i++) begin
            if (i < 6) bus_drive(16'hF800, 16'h00A0 + 16'(i));
            else       bus_idle();
            step();
            if (i > 0) line_q.push_back(tx);
            if (i == 5) begin
                bus_idle();
                #1;
                chk("ovf_stat", bus_if.rd_data, 32'h004B);
            end
        end
        for (int b = 0; b < 5; b++) add_frame(8'hA0 + 8'(b));
        add_idle(7);
        check_line("ovf_line");
        #1;
        chk("ovf_sticky", bus_if.rd_data, 32'h000C);
        bus_write(16'hF801, 16'h0000);
        chk("ovf_clear", bus_if.rd_data, 32'h0004);

        // Simultaneous push/pop, including at STOP end
        for (int i = 0; i < 121; i++) begin
            if (i == 0)       bus_drive(16'hF800, 16'h0081);
            else if (i == 1)  bus_drive(16'hF800, 16'h00C3);
            else if (i == 41) bus_drive(16'hF800, 16'h0017);
            else              bus_idle();
            step();
            if (i > 0) line_q.push_back(tx);
            bus_idle();
            #1;
            if (i == 1)  chk("pp_first", bus_if.rd_data, 32'h0011);
            if (i == 41) chk("pp_stop", bus_if.rd_data, 32'h0011);
        end
        add_frame(8'h81);
        add_frame(8'hC3);
        add_frame(8'h17);
        check_line("pp_line");
        step();
        chk("pp_done", bus_if.rd_data, 32'h0004);

        // Reset in the middle of DATA bit 3
        bus_write(16'hF800, 16'h00F0);
        bus_write(16'hF800, 16'h000F);
        repeat (17) step();
        chk("mid_bit3", {31'd0, tx}, 32'd0);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_async_tx", {31'd0, tx}, 32'd1);
        chk("mid_async_stat", bus_if.rd_data, 32'h0004);
        step();
        step();
        rst = 1'b1;
        saw_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (tx !== 1'b1) saw_low = 1'b1;
        end
        chk("mid_no_resume", {31'd0, saw_low}, 32'd0);
        chk("mid_stat", bus_if.rd_data, 32'h0004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
